// File: rtl/regfile_wport_arb.sv
// Write-port arbiter for the 32-entry register file with a pending-write scoreboard.
// Writeback always wins; mul/div and load returns share the remaining slots round-robin.
module regfile_wport_arb #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_we,
  input  logic [4:0]            wb_waddr,
  input  logic [DATA_WIDTH-1:0] wb_wdata,
  input  logic                  md_valid,
  output logic                  md_ready,
  input  logic [4:0]            md_waddr,
  input  logic [DATA_WIDTH-1:0] md_wdata,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [4:0]            ld_waddr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_rd,
  input  logic [4:0]            raddrA,
  input  logic [4:0]            raddrB,
  output logic                  busy_a,
  output logic                  busy_b,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  wb_stall
);

  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;

  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  busy_nxt;
  logic             rr_ptr;
  logic             rr_ptr_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_nxt;

  logic             md_gnt;
  logic             ld_gnt;
  logic             lo_gnt;
  logic [AW-1:0]    lo_waddr;

  // Grant selection; reset suppresses every grant so an in-flight request is dropped.
  always_comb begin
    md_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (rst_n && !wb_we) begin
      if (md_valid && ld_valid) begin
        md_gnt = !rr_ptr;
        ld_gnt = rr_ptr;
      end else begin
        md_gnt = md_valid;
        ld_gnt = ld_valid;
      end
    end
  end

  assign lo_gnt   = md_gnt || ld_gnt;
  assign lo_waddr = md_gnt ? md_waddr : ld_waddr;
  assign md_ready = md_gnt;
  assign ld_ready = ld_gnt;

  // Write-port mux; r0 writes still handshake but never assert the enable.
  always_comb begin
    rf_waddr = ld_waddr;
    rf_wdata = ld_wdata;
    if (wb_we) begin
      rf_waddr = wb_waddr;
      rf_wdata = wb_wdata;
    end else if (md_gnt) begin
      rf_waddr = md_waddr;
      rf_wdata = md_wdata;
    end
  end

  assign rf_we = rst_n && (wb_we || lo_gnt) && (rf_waddr != AW'(0));

  // A register being written this cycle is forwarded by the regfile, so it is not busy.
  assign busy_a = busy[raddrA] && !(lo_gnt && (lo_waddr == raddrA));
  assign busy_b = busy[raddrB] && !(lo_gnt && (lo_waddr == raddrB));

  assign wb_stall = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Next-state: scoreboard clear-then-set (set wins), pointer and starvation counter.
  always_comb begin
    busy_nxt       = busy;
    rr_ptr_nxt     = rr_ptr;
    starve_cnt_nxt = starve_cnt;

    if (lo_gnt) begin
      busy_nxt[lo_waddr] = 1'b0;
      rr_ptr_nxt         = md_gnt;
    end
    if (issue_valid) begin
      busy_nxt[issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;

    if (lo_gnt || !(md_valid || ld_valid)) begin
      starve_cnt_nxt = '0;
    end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
      starve_cnt_nxt = starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      rr_ptr     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      busy       <= busy_nxt;
      rr_ptr     <= rr_ptr_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Bench for regfile_wport_arb: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_regfile_wport_arb;

  localparam int unsigned DW    = 32;
  localparam int unsigned LIMIT = 4;

  logic          clk;
  logic          rst_n;
  logic          wb_we;
  logic [4:0]    wb_waddr;
  logic [DW-1:0] wb_wdata;
  logic          md_valid, md_ready;
  logic [4:0]    md_waddr;
  logic [DW-1:0] md_wdata;
  logic          ld_valid, ld_ready;
  logic [4:0]    ld_waddr;
  logic [DW-1:0] ld_wdata;
  logic          issue_valid;
  logic [4:0]    issue_rd;
  logic [4:0]    raddrA, raddrB;
  logic          busy_a, busy_b;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          wb_stall;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit m_busy [32];
  bit m_md_pref;
  int m_starve;

  // Register file stub fed by the DUT write port
  logic [DW-1:0] tb_rf [32];

  regfile_wport_arb dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .md_valid(md_valid), .md_ready(md_ready), .md_waddr(md_waddr), .md_wdata(md_wdata),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_waddr(ld_waddr), .ld_wdata(ld_wdata),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .raddrA(raddrA), .raddrB(raddrB), .busy_a(busy_a), .busy_b(busy_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_stall(wb_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_we) tb_rf[rf_waddr] <= rf_wdata;
  end

  task automatic drive_idle();
    wb_we = 0; wb_waddr = 0; wb_wdata = 0;
    md_valid = 0; md_waddr = 0; md_wdata = 0;
    ld_valid = 0; ld_waddr = 0; ld_wdata = 0;
    issue_valid = 0; issue_rd = 0; raddrA = 0; raddrB = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 0;
    #7;
    for (int i = 0; i < 32; i++) begin
      m_busy[i] = 0;
      tb_rf[i]  = '0;
    end
    m_md_pref = 1;
    m_starve  = 0;
    @(posedge clk);
    #1 rst_n = 1;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 0;
    md_valid = 1; md_waddr = 5'd3; ld_valid = 1; ld_waddr = 5'd4;
    wb_we = 1; wb_waddr = 5'd2;
    #3;
    n_checks++; if (md_ready !== 1'b0) $display("FAIL reset_md_ready got=%b exp=0", md_ready); else n_pass++;
    n_checks++; if (ld_ready !== 1'b0) $display("FAIL reset_ld_ready got=%b exp=0", ld_ready); else n_pass++;
    n_checks++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we got=%b exp=0", rf_we); else n_pass++;
    n_checks++; if ({busy_a, busy_b, wb_stall} !== 3'b000)
      $display("FAIL reset_busy_stall got=%b exp=000", {busy_a, busy_b, wb_stall}); else n_pass++;
    do_reset();
  endtask

  task automatic test_md_write();
    do_reset();
    md_valid = 1; md_waddr = 5'd5; md_wdata = 32'h1234;
    #2;
    n_checks++; if (md_ready !== 1'b1) $display("FAIL mdw_ready got=%b exp=1", md_ready); else n_pass++;
    n_checks++; if (rf_we !== 1'b1) $display("FAIL mdw_rf_we got=%b exp=1", rf_we); else n_pass++;
    n_checks++; if (rf_waddr !== 5'd5) $display("FAIL mdw_waddr got=%0d exp=5", rf_waddr); else n_pass++;
    n_checks++; if (rf_wdata !== 32'h1234) $display("FAIL mdw_wdata got=%h exp=1234", rf_wdata); else n_pass++;
    step();
    md_valid = 0;
    #1;
    n_checks++; if (tb_rf[5] !== 32'h1234) $display("FAIL mdw_r5 got=%h exp=1234", tb_rf[5]); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic exp_md;
    do_reset();
    md_waddr = 5'd3; md_wdata = 32'hA3;
    ld_waddr = 5'd4; ld_wdata = 32'hB4;
    md_valid = 1; ld_valid = 1;
    for (int i = 0; i < 4; i++) begin
      exp_md = (i % 2 == 0);
      #2;
      n_checks++; if ({md_ready, ld_ready} !== {exp_md, !exp_md})
        $display("FAIL rr_alt%0d got md=%b ld=%b exp md=%b", i, md_ready, ld_ready, exp_md); else n_pass++;
      step();
      md_valid = !exp_md;
      ld_valid = exp_md;
    end
    md_valid = 1; ld_valid = 1;
    for (int i = 0; i < 2; i++) begin
      exp_md = (i == 0);
      #2;
      n_checks++; if ({md_ready, ld_ready} !== {exp_md, !exp_md})
        $display("FAIL rr_tie%0d got md=%b ld=%b exp md=%b", i, md_ready, ld_ready, exp_md); else n_pass++;
      step();
    end
    drive_idle();
  endtask

  task automatic test_starvation();
    do_reset();
    wb_we = 1; wb_waddr = 5'd1; wb_wdata = 32'h55;
    md_valid = 1; md_waddr = 5'd6; md_wdata = 32'h66;
    for (int c = 1; c <= 7; c++) begin
      #2;
      n_checks++; if (md_ready !== 1'b0) $display("FAIL starve_ready c%0d got=%b exp=0", c, md_ready); else n_pass++;
      n_checks++; if (wb_stall !== (c >= 5)) $display("FAIL starve_stall c%0d got=%b exp=%b", c, wb_stall, c >= 5); else n_pass++;
      n_checks++; if (rf_waddr !== 5'd1) $display("FAIL starve_waddr c%0d got=%0d exp=1", c, rf_waddr); else n_pass++;
      step();
    end
    wb_we = 0;
    #2;
    n_checks++; if (md_ready !== 1'b1) $display("FAIL starve_release got=%b exp=1", md_ready); else n_pass++;
    step();
    md_valid = 0;
    #1;
    n_checks++; if (wb_stall !== 1'b0) $display("FAIL starve_clear got=%b exp=0", wb_stall); else n_pass++;
  endtask

  task automatic test_scoreboard();
    do_reset();
    issue_valid = 1; issue_rd = 5'd7;
    step();
    issue_valid = 0; raddrA = 5'd7;
    #2;
    n_checks++; if (busy_a !== 1'b1) $display("FAIL sb_set got=%b exp=1", busy_a); else n_pass++;
    ld_valid = 1; ld_waddr = 5'd7; ld_wdata = 32'h77;
    #1;
    n_checks++; if ({ld_ready, busy_a} !== 2'b10) $display("FAIL sb_fwd got=%b exp=10", {ld_ready, busy_a}); else n_pass++;
    step();
    ld_valid = 0;
    #1;
    n_checks++; if (busy_a !== 1'b0) $display("FAIL sb_clear got=%b exp=0", busy_a); else n_pass++;
    issue_valid = 1; issue_rd = 5'd9;
    md_valid = 1; md_waddr = 5'd9; md_wdata = 32'h99;
    step();
    drive_idle();
    raddrB = 5'd9;
    #1;
    n_checks++; if (busy_b !== 1'b1) $display("FAIL sb_setwins got=%b exp=1", busy_b); else n_pass++;
  endtask

  task automatic test_r0_and_async_reset();
    do_reset();
    ld_valid = 1; ld_waddr = 5'd0; ld_wdata = 32'hFFFF; raddrA = 5'd0;
    #2;
    n_checks++; if ({ld_ready, rf_we, busy_a} !== 3'b100)
      $display("FAIL r0_write got=%b exp=100", {ld_ready, rf_we, busy_a}); else n_pass++;
    step();
    ld_valid = 0;
    #1;
    n_checks++; if (tb_rf[0] !== 32'h0) $display("FAIL r0_value got=%h exp=0", tb_rf[0]); else n_pass++;
    issue_valid = 1; issue_rd = 5'd12;
    step();
    issue_valid = 0; raddrB = 5'd12;
    wb_we = 1; wb_waddr = 5'd2; md_valid = 1; md_waddr = 5'd12;
    for (int c = 0; c < 5; c++) step();
    n_checks++; if ({busy_b, wb_stall} !== 2'b11)
      $display("FAIL rst_pre got=%b exp=11", {busy_b, wb_stall}); else n_pass++;
    #2 rst_n = 0;
    #1;
    n_checks++; if ({md_ready, rf_we, busy_b, wb_stall} !== 4'b0000)
      $display("FAIL rst_mid got=%b exp=0000", {md_ready, rf_we, busy_b, wb_stall}); else n_pass++;
    do_reset();
  endtask

  task automatic test_random(input int ncyc);
    int            g;
    int            wb_pct;
    logic [4:0]    ga;
    logic [DW-1:0] gd;
    logic          e_we, e_ba, e_bb, e_stall;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      wb_pct = ((c / 40) % 2 == 1) ? 85 : 15;
      if (!md_valid && $urandom_range(0, 1) == 1) begin
        md_valid = 1; md_waddr = 5'($urandom_range(0, 7)); md_wdata = $urandom;
      end
      if (!ld_valid && $urandom_range(0, 1) == 1) begin
        ld_valid = 1; ld_waddr = 5'($urandom_range(0, 7)); ld_wdata = $urandom;
      end
      wb_we       = ($urandom_range(0, 99) < wb_pct);
      wb_waddr    = 5'($urandom_range(0, 31));
      wb_wdata    = $urandom;
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = 5'($urandom_range(0, 7));
      raddrA      = 5'($urandom_range(0, 7));
      raddrB      = 5'($urandom_range(0, 7));

      // g: -1 none, 0 writeback, 1 mul/div, 2 load
      if (wb_we) g = 0;
      else if (md_valid && ld_valid) g = m_md_pref ? 1 : 2;
      else if (md_valid) g = 1;
      else if (ld_valid) g = 2;
      else g = -1;
      ga = (g == 0) ? wb_waddr : (g == 1) ? md_waddr : ld_waddr;
      gd = (g == 0) ? wb_wdata : (g == 1) ? md_wdata : ld_wdata;
      e_we    = (g >= 0) && (ga != 0);
      e_ba    = m_busy[raddrA] && !(g > 0 && ga == raddrA);
      e_bb    = m_busy[raddrB] && !(g > 0 && ga == raddrB);
      e_stall = (m_starve == LIMIT);
      #2;
      n_checks++; if ({md_ready, ld_ready} !== {g == 1, g == 2})
        $display("FAIL rnd_grant c%0d got md=%b ld=%b exp g=%0d", c, md_ready, ld_ready, g); else n_pass++;
      n_checks++; if (rf_we !== e_we) $display("FAIL rnd_we c%0d got=%b exp=%b", c, rf_we, e_we); else n_pass++;
      if (e_we) begin
        n_checks++; if ({rf_waddr, rf_wdata} !== {ga, gd})
          $display("FAIL rnd_wr c%0d got=%0d/%h exp=%0d/%h", c, rf_waddr, rf_wdata, ga, gd); else n_pass++;
      end
      n_checks++; if ({busy_a, busy_b} !== {e_ba, e_bb})
        $display("FAIL rnd_busy c%0d got=%b%b exp=%b%b", c, busy_a, busy_b, e_ba, e_bb); else n_pass++;
      n_checks++; if (wb_stall !== e_stall) $display("FAIL rnd_stall c%0d got=%b exp=%b", c, wb_stall, e_stall); else n_pass++;
      @(posedge clk);
      if (g > 0) begin
        m_busy[ga] = 0;
        m_md_pref  = (g == 2);
      end
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1;
      if (g > 0 || !(md_valid || ld_valid)) m_starve = 0;
      else if (m_starve < LIMIT) m_starve++;
      #1;
      if (g == 1) md_valid = 0;
      if (g == 2) ld_valid = 0;
    end
    drive_idle();
  endtask

  initial begin
    rst_n = 0;
    drive_idle();
    test_reset();
    test_md_write();
    test_round_robin();
    test_starvation();
    test_scoreboard();
    test_r0_and_async_reset();
    test_random(400);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
